// File: rtl/ram_block_reader_pkg.sv
// rtl/ram_block_reader_pkg.sv - FSM encoding and buffer constants shared by the RAM block reader
package ram_block_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

endpackage

// File: rtl/ram_block_reader_if.sv
// rtl/ram_block_reader_if.sv - valid/ready stream port carrying data words with a last flag
interface ram_block_reader_if #(
    parameter int WIDTH = 64
);

    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/ram_rd_skid.sv
// rtl/ram_rd_skid.sv - small FIFO of {last, data} that absorbs words returned by the RAM
module ram_rd_skid
    import ram_block_reader_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH:0]   push_data_i,
    input  logic             pop_i,
    output logic [WIDTH:0]   head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH:0]   mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && ((count_q != CNT_W'(BUF_DEPTH)) || pop_i);
    assign pop_ok  = pop_i && (count_q != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_block_reader.sv
// rtl/ram_block_reader.sv - streams a block of RAM words out; RAM_BLOCK_READER_LOOP_EN adds repeat passes
module ram_block_reader
    import ram_block_reader_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int SIZE  = 512,
    localparam int ABITS = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ABITS-1:0]   base_addr,
    input  logic [ABITS:0]     length,
    output logic               busy,
    output logic               done,
    output logic               ram_rden,
    output logic [ABITS-1:0]   ram_rdaddr,
    input  logic [WIDTH-1:0]   ram_rddata,
`ifdef RAM_BLOCK_READER_LOOP_EN
    input  logic               loop,
`endif
    ram_block_reader_if.master m_if
);

    state_e           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [ABITS:0]   remaining_q, remaining_d;
    logic             inflight_q;
    logic             inflight_last_q;
`ifdef RAM_BLOCK_READER_LOOP_EN
    logic [ABITS-1:0] base_q, base_d;
    logic [ABITS:0]   length_q, length_d;
`endif

    logic             issue;
    logic             issue_last;
    logic             pop;
    logic [WIDTH:0]   head;
    logic [CNT_W-1:0] buf_count;
    logic [2:0]       occ;

    function automatic logic [ABITS-1:0] next_addr(input logic [ABITS-1:0] a);
        return (a == ABITS'(SIZE - 1)) ? '0 : a + ABITS'(1);
    endfunction

    // Only issue a read if the buffer can still hold it once the in-flight word lands.
    assign pop        = m_if.m_valid & m_if.m_ready;
    assign occ        = 3'(buf_count) + 3'(inflight_q);
    assign issue      = (state_q == ST_RUN) && (remaining_q != '0) &&
                        (occ < (3'(BUF_DEPTH) + 3'(pop)));
    assign issue_last = issue && (remaining_q == (ABITS+1)'(1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done        = 1'b0;
`ifdef RAM_BLOCK_READER_LOOP_EN
        base_d      = base_q;
        length_d    = length_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length;
`ifdef RAM_BLOCK_READER_LOOP_EN
                    base_d      = base_addr;
                    length_d    = length;
`endif
                    state_d     = (length == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    remaining_d = remaining_q - (ABITS+1)'(1);
                    addr_d      = next_addr(addr_q);
                    if (issue_last) begin
`ifdef RAM_BLOCK_READER_LOOP_EN
                        if (loop) begin
                            remaining_d = length_q;
                            addr_d      = base_q;
                        end else begin
                            state_d = ST_DRAIN;
                        end
`else
                        state_d = ST_DRAIN;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                // The final word is the one that empties the buffer with nothing left in flight.
                if (pop && head[WIDTH] && (buf_count == CNT_W'(1)) && !inflight_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
        end
    end

`ifdef RAM_BLOCK_READER_LOOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            length_q <= '0;
        end else begin
            base_q   <= base_d;
            length_q <= length_d;
        end
    end
`endif

    ram_rd_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, ram_rddata}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (buf_count)
    );

    assign busy         = (state_q != ST_IDLE);
    assign ram_rden     = issue;
    assign ram_rdaddr   = addr_q;
    assign m_if.m_valid = (buf_count != '0);
    assign m_if.m_data  = head[WIDTH-1:0];
    assign m_if.m_last  = m_if.m_valid & head[WIDTH];

endmodule

// File: doc/ram_block_reader.md
Name: ram_block_reader

Overview:
- Read-side initiator for the team's dual-port `ram`: given a start address and a length, drives `rden`/`rdaddr`, absorbs the RAM's 1-cycle read latency, and streams words out on a valid/ready master port with a last flag.
- Sits between a RAM buffer (filled by a separate writer) and downstream stream consumers such as DMA or FFT input.
- Sustains one word per cycle under continuous ready and loses no data under backpressure.

Parameters:
- WIDTH, 64, data word width; must match the attached `ram`.
- SIZE, 512, RAM depth in words; ABITS = $clog2(SIZE) is a derived localparam.

Ports:
- clk  input  1  single clock; ties to the RAM's `rdclk`.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ABITS  first address; captured on accepted start.
- length  input  ABITS+1  number of words (0..SIZE); captured on accepted start.
- busy  output  1  high while a command is active.
- done  output  1  one-cycle completion pulse.
- ram_rden  output  1  to `ram.rden`.
- ram_rdaddr  output  ABITS  to `ram.rdaddr`.
- ram_rddata  input  WIDTH  from `ram.rddata`; valid the cycle after `ram_rden`.
- m_valid  output  1  stream data valid.
- m_data  output  WIDTH  stream data.
- m_last  output  1  marks the final word of a command.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, ram_rden, m_valid, m_last = 0; ram_rdaddr = 0; buffer emptied.
- FSM:
  - IDLE: start=1 captures base_addr and length. If length≠0, go to RUN. If length=0, go to FIN.
  - RUN: issue reads. When the last read has been issued, go to DRAIN.
  - DRAIN: wait for the final beat handshake, then go to FIN.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- busy = (state≠IDLE).
- start is ignored outside IDLE.
- Read issue in RUN: ram_rden=1 when remaining>0 and (buf_count + inflight − pop) < 2, where:
  - pop = m_valid & m_ready;
  - inflight = ram_rden registered 1 cycle.
- The rule above guarantees the 2-entry buffer never overflows.
- Addressing:
  - ram_rdaddr starts at base_addr and increments by 1 per issued read.
  - Wraps modulo SIZE; non-power-of-2 SIZE wraps SIZE−1 → 0 explicitly.
  - ram_rdaddr holds its value when ram_rden=0.
- Capture: when inflight=1, ram_rddata is written into a 2-entry FIFO along with a last tag. The last tag is 1 for the word issued when remaining was 1.
- Output: m_valid = buffer non-empty; m_data/m_last = head entry.
- Once m_valid=1, m_data and m_last are held stable until the handshake.
- Latency: start accepted at edge 0 → ram_rden high in cycle 1 → m_valid high after edge 2.
- Throughput: with m_ready held high, one beat per cycle; L words finish in L+2 cycles, and done rises the cycle after the last handshake.
- Backpressure:
  - m_ready low stalls issue after at most 2 words are buffered or in flight.
  - On resume, no duplicate and no dropped words.
- length=SIZE reads every location exactly once, wrapping through the full address range.
- Simultaneous events: a FIFO push and pop in the same cycle keeps buf_count unchanged.
- Reset mid-operation: immediate abort; no done pulse; any partially returned data is discarded.
- Counter width: remaining is ABITS+1 bits; no arithmetic exceeds that width.

Optional Feature:
- Macro: RAM_BLOCK_READER_LOOP_EN.
- When defined:
  - Adds input port `loop` (1 bit).
  - If loop=1 when the last read is issued in RUN, the reader re-arms remaining=length and ram_rdaddr=base_addr and stays in RUN.
  - m_last still marks every pass boundary; done pulses only after the final pass, i.e. when loop=0 at the last issue.
  - Streaming across passes has no bubble.
- When undefined: no `loop` port; single pass per start.

Decomposition:
- Package `ram_block_reader_pkg`: FSM state encoding (IDLE, RUN, DRAIN, FIN); buffer depth constant BUF_DEPTH=2.
- Sub-module `ram_rd_skid`: 2-entry FIFO of {last, data}, with push/pop/count. Instantiated once; replaceable by a deeper buffer if issue timing is relaxed later.

Test Plan:
1. base_addr=5, length=4, m_ready=1, RAM preloaded mem[i]=i → m_data 5,6,7,8 on consecutive cycles; m_valid first high 2 cycles after start; m_last on 8; done 1 cycle after.
2. base_addr=510, length=4, SIZE=512 → addresses 510,511,0,1 read in order; no access to address 512.
3. length=8 with m_ready toggling 1,0,0,1 repeating → all 8 words delivered exactly once in order; m_data stable while stalled; ram_rden never pushes the buffer past 2 entries.
4. length=0 → no ram_rden; busy for 1 cycle; done pulse; no m_valid.
5. rst_n pulsed low at word 3 of length=10, then new start with base_addr=0, length=2 → no done from the aborted command; only mem[0], mem[1] emitted.
6. LOOP_EN build: loop=1 for two passes, base_addr=0, length=3 → sequence 0,1,2,0,1,2 with no bubble; m_last on each 2; single done after the second pass.
